sys_tick_scheduler: RTL and testbench
=====================================

# sys_tick_scheduler

Bus-master controller for the 16-bit Avalon system interval timer. It programs the timer period, starts it in continuous interrupt mode and verifies that it is running. It then services every timeout by clearing the timer status and fans the base tick out to NUM_CH divided periodic tick pulses for the gait/servo update loops. It replaces the software ISR that used to own the timer, and sits between the timer's slave port and the control datapath.

## Interface
- NUM_CH, 4, number of divided tick channels
- DIV_W, 8, width of each channel divider
- clk  in  1  system clock; shared with the timer
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  level; high = run the timer, low = stop it
- cfg_period  in  32  base tick period in clk cycles; legal range ≥ 4
- cfg_div  in  NUM_CH*DIV_W  per-channel divider; channel i uses bits [i*DIV_W +: DIV_W]; 0 = channel disabled
- tmr_address  out  3  timer register address
- tmr_chipselect  out  1  timer select
- tmr_write_n  out  1  active-low write
- tmr_writedata  out  16  write data
- tmr_readdata  in  16  timer read data; registered by the timer, valid the cycle after the address is presented
- tmr_irq  in  1  timer interrupt; level
- tick  out  NUM_CH  one-cycle divided tick pulses
- tick_count  out  32  base ticks serviced since start; wraps
- running  out  1  timer verified running and being serviced
- error  out  1  sticky start-verification or configuration failure

## Operation
- Timer register map:
  - 0 = status: bit0 TO, bit1 RUN; any write clears TO
  - 1 = control: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP
  - 2 = period_l
  - 3 = period_h
- States: IDLE, WR_PL, WR_PH, WR_CTRL, RD_STAT, RD_WAIT, RUN, CLR, STOP, ERR.
- IDLE:
  - Bus idle: chipselect=0, write_n=1, address=0, writedata=0.
  - If enable=1 and cfg_period<4, go to ERR.
  - If enable=1 and cfg_period≥4, latch load = cfg_period-1 and latch cfg_div, then go to WR_PL.
- WR_PL: write load[15:0] to address 2, then go to WR_PH.
- WR_PH: write load[31:16] to address 3, then go to WR_CTRL.
- WR_CTRL: write 0x0007 to address 1 (ITO|CONT|START), then go to RD_STAT.
- RD_STAT: chipselect=1, write_n=1, address 0, then go to RD_WAIT.
- RD_WAIT: sample tmr_readdata.
  - bit1=1: set running=1, clear tick_count and all channel counters, go to RUN.
  - Otherwise: set error=1, go to STOP.
- RUN:
  - enable=0: go to STOP.
  - Else tmr_irq=1: go to CLR.
  - enable=0 has priority over tmr_irq.
- CLR:
  - Write 0x0000 to address 0.
  - tick_count += 1.
  - For each channel with d≠0: if cnt_i == d-1, pulse tick[i] and set cnt_i=0; else cnt_i += 1.
  - Return to RUN.
- STOP: write 0x0008 to address 1 (STOP, ITO off), clear running.
  - If error=1, go to ERR; otherwise go to IDLE.
- ERR: bus idle, error held at 1; go to IDLE when enable=0, clearing error on that transition.
- enable falling during WR_PL..RD_WAIT: the current bus cycle completes, then the block goes to STOP (RD_WAIT does not set running).
- cfg_period and cfg_div changes while not in IDLE are ignored until the next start.
- Divider arithmetic is modulo d; a DIV_W-bit d of all ones is legal.

## Timing
- Reset values:
  - tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0
  - tick=0, tick_count=0, running=0, error=0
  - state IDLE; all counters 0
- All outputs are registered; each bus access lasts exactly one cycle with no wait states.
- Start latency: enable high at edge E gives:
  - period_l write in cycle E+1, period_h in E+2, control in E+3
  - status read in E+4, sampled in E+5
  - running=1 from E+6
- Service latency:
  - tmr_irq seen in RUN at cycle T; status clear occurs in cycle T+1.
  - tick and tick_count update are visible in T+2.
  - tmr_irq is low by T+2, so one timeout produces exactly one service.
- Timeout coinciding with the clear write: the timer's clear wins and that tick is lost. The minimum cfg_period of 4 prevents this.
- Stop latency from RUN: enable low at T gives the control write in T+1, running=0 in T+2.
- Reset mid-operation returns the block to IDLE immediately; the timer is reset by the same reset_n.

## Test plan
- Start: cfg_period=100, enable=1.
  - Writes required in order: 0x0063@2, 0x0000@3, 0x0007@1, then a read @0.
  - running=1 six cycles after enable.
  - tmr_irq period 100 cycles.
- Dividers: cfg_div = {0,3,2,1}, run 12 base ticks.
  - tick[0] pulses 12 times, tick[1] 6, tick[2] 4, tick[3] 0.
  - tick_count=12.
- Stop mid-run: drop enable between ticks.
  - Required: write 0x0008@1, running=0, no further tmr_irq, tick_count frozen.
- Config error: cfg_period=3, enable=1.
  - error=1, no bus writes issued.
  - enable=0 clears error and returns the block to IDLE.
- Verify failure: model the timer returning status bit1=0.
  - error=1, STOP write 0x0008@1 issued, running stays 0.
- Reset asserted during WR_PH: all outputs return to reset values; a later enable performs a full restart sequence.

Source files
------------

// File: rtl/sys_tick_scheduler.sv
// rtl/sys_tick_scheduler.sv - Avalon interval-timer bus master with divided tick fan-out
// Programs, starts and verifies the timer, then services each timeout and derives NUM_CH ticks.
module sys_tick_scheduler #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [31:0]             cfg_period,
  input  logic [NUM_CH*DIV_W-1:0] cfg_div,
  output logic [2:0]              tmr_address,
  output logic                    tmr_chipselect,
  output logic                    tmr_write_n,
  output logic [15:0]             tmr_writedata,
  input  logic [15:0]             tmr_readdata,
  input  logic                    tmr_irq,
  output logic [NUM_CH-1:0]       tick,
  output logic [31:0]             tick_count,
  output logic                    running,
  output logic                    error
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_RD_STAT,
    S_RD_WAIT, S_RUN, S_CLR, S_STOP, S_ERR
  } state_t;

  state_t                          state, state_n;
  logic [31:0]                     load, load_n;
  logic [NUM_CH-1:0][DIV_W-1:0]    div_q, div_n;
  logic [NUM_CH-1:0][DIV_W-1:0]    cnt, cnt_n;
  logic [NUM_CH-1:0]               tick_n;
  logic [31:0]                     tick_count_n;
  logic                            running_n, error_n;
  logic [2:0]                      addr_n;
  logic                            cs_n, wr_n_n;
  logic [15:0]                     wdata_n;
  logic                            unused_rd;

  assign unused_rd = ^{tmr_readdata[15:2], tmr_readdata[0]};

  always_comb begin
    state_n      = state;
    load_n       = load;
    div_n        = div_q;
    cnt_n        = cnt;
    tick_n       = '0;
    tick_count_n = tick_count;
    running_n    = running;
    error_n      = error;

    case (state)
      S_IDLE: begin
        if (enable) begin
          if (cfg_period < 32'd4) begin
            error_n = 1'b1;
            state_n = S_ERR;
          end else begin
            load_n  = cfg_period - 32'd1;
            div_n   = cfg_div;
            state_n = S_WR_PL;
          end
        end
      end
      S_WR_PL:   state_n = enable ? S_WR_PH   : S_STOP;
      S_WR_PH:   state_n = enable ? S_WR_CTRL : S_STOP;
      S_WR_CTRL: state_n = enable ? S_RD_STAT : S_STOP;
      S_RD_STAT: state_n = enable ? S_RD_WAIT : S_STOP;
      S_RD_WAIT: begin
        // A stop request during verification wins over the status result.
        if (!enable) begin
          state_n = S_STOP;
        end else if (tmr_readdata[1]) begin
          running_n    = 1'b1;
          tick_count_n = '0;
          cnt_n        = '0;
          state_n      = S_RUN;
        end else begin
          error_n = 1'b1;
          state_n = S_STOP;
        end
      end
      S_RUN: begin
        if (!enable)      state_n = S_STOP;
        else if (tmr_irq) state_n = S_CLR;
      end
      S_CLR: begin
        tick_count_n = tick_count + 32'd1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (div_q[i] != '0) begin
            if (cnt[i] == div_q[i] - DIV_W'(1)) begin
              tick_n[i] = 1'b1;
              cnt_n[i]  = '0;
            end else begin
              cnt_n[i] = cnt[i] + DIV_W'(1);
            end
          end
        end
        state_n = S_RUN;
      end
      S_STOP: begin
        running_n = 1'b0;
        state_n   = error ? S_ERR : S_IDLE;
      end
      S_ERR: begin
        if (!enable) begin
          error_n = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Bus outputs are registered from the state being entered, so each access lands in its own cycle.
    cs_n    = 1'b0;
    wr_n_n  = 1'b1;
    addr_n  = 3'd0;
    wdata_n = 16'h0000;
    case (state_n)
      S_WR_PL:   begin cs_n = 1'b1; wr_n_n = 1'b0; addr_n = 3'd2; wdata_n = load_n[15:0];  end
      S_WR_PH:   begin cs_n = 1'b1; wr_n_n = 1'b0; addr_n = 3'd3; wdata_n = load_n[31:16]; end
      S_WR_CTRL: begin cs_n = 1'b1; wr_n_n = 1'b0; addr_n = 3'd1; wdata_n = 16'h0007;      end
      S_RD_STAT: begin cs_n = 1'b1; end
      S_CLR:     begin cs_n = 1'b1; wr_n_n = 1'b0; end
      S_STOP:    begin cs_n = 1'b1; wr_n_n = 1'b0; addr_n = 3'd1; wdata_n = 16'h0008;      end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      load           <= '0;
      div_q          <= '0;
      cnt            <= '0;
      tick           <= '0;
      tick_count     <= '0;
      running        <= 1'b0;
      error          <= 1'b0;
      tmr_address    <= 3'd0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_writedata  <= 16'h0000;
    end else begin
      state          <= state_n;
      load           <= load_n;
      div_q          <= div_n;
      cnt            <= cnt_n;
      tick           <= tick_n;
      tick_count     <= tick_count_n;
      running        <= running_n;
      error          <= error_n;
      tmr_address    <= addr_n;
      tmr_chipselect <= cs_n;
      tmr_write_n    <= wr_n_n;
      tmr_writedata  <= wdata_n;
    end
  end

endmodule

// File: tb/tb_sys_tick_scheduler.sv
// tb/tb_sys_tick_scheduler.sv - self-checking bench for sys_tick_scheduler
// Contains a behavioural interval-timer slave and a scoreboard of expected bus writes.
module tb_sys_tick_scheduler;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    enable = 1'b0;
  logic [31:0]             cfg_period = '0;
  logic [NUM_CH*DIV_W-1:0] cfg_div = '0;
  logic [2:0]              tmr_address;
  logic                    tmr_chipselect;
  logic                    tmr_write_n;
  logic [15:0]             tmr_writedata;
  logic [15:0]             tmr_readdata;
  logic                    tmr_irq;
  logic [NUM_CH-1:0]       tick;
  logic [31:0]             tick_count;
  logic                    running;
  logic                    error;

  sys_tick_scheduler #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_period(cfg_period), .cfg_div(cfg_div),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
    .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq),
    .tick(tick), .tick_count(tick_count), .running(running), .error(error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Timer slave model
  logic        fail_run = 1'b0;
  logic [15:0] per_l, per_h;
  logic [31:0] tcnt;
  logic        t_to, t_run, t_ito, t_cont;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_l <= '0; per_h <= '0; tcnt <= '0;
      t_to <= 1'b0; t_run <= 1'b0; t_ito <= 1'b0; t_cont <= 1'b0;
      tmr_readdata <= '0;
    end else begin
      if (t_run) begin
        if (tcnt == 0) begin
          t_to <= 1'b1;
          tcnt <= {per_h, per_l};
          if (!t_cont) t_run <= 1'b0;
        end else begin
          tcnt <= tcnt - 1;
        end
      end
      if (tmr_chipselect && !tmr_write_n) begin
        case (tmr_address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            t_ito  <= tmr_writedata[0];
            t_cont <= tmr_writedata[1];
            if (tmr_writedata[2]) begin t_run <= 1'b1; tcnt <= {per_h, per_l}; end
            if (tmr_writedata[3]) t_run <= 1'b0;
          end
          3'd2: per_l <= tmr_writedata;
          3'd3: per_h <= tmr_writedata;
          default: ;
        endcase
      end
      tmr_readdata <= (tmr_chipselect && tmr_write_n && tmr_address == 3'd0) ?
                      {14'd0, t_run & ~fail_run, t_to} : 16'h0000;
    end
  end
  assign tmr_irq = t_to & t_ito;

  // Scoreboard and monitors
  logic [18:0] exp_wr[$];
  int cyc = 0;
  int tick_seen[NUM_CH];
  int n_clr = 0;
  int last_clr = -1;
  int exp_period = 0;
  int irq_rises = 0;
  logic irq_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      for (int i = 0; i < NUM_CH; i++) if (tick[i]) tick_seen[i]++;
      if (tmr_irq && !irq_d) irq_rises++;
      irq_d = tmr_irq;
      if (tmr_chipselect && !tmr_write_n) begin
        if (tmr_address == 3'd0) begin
          check_eq("clr_data", tmr_writedata, 0);
          if (last_clr >= 0) check_eq("clr_interval", cyc - last_clr, exp_period);
          last_clr = cyc;
          n_clr++;
        end else begin
          check_eq("wr_pending", exp_wr.size() > 0, 1);
          if (exp_wr.size() > 0) check_eq("wr_addr_data", {tmr_address, tmr_writedata}, exp_wr.pop_front());
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_cs"},    tmr_chipselect, 0);
    check_eq({tag, "_wr_n"},  tmr_write_n, 1);
    check_eq({tag, "_addr"},  tmr_address, 0);
    check_eq({tag, "_wdata"}, tmr_writedata, 0);
    check_eq({tag, "_tick"},  tick, 0);
    check_eq({tag, "_count"}, tick_count, 0);
    check_eq({tag, "_run"},   running, 0);
    check_eq({tag, "_err"},   error, 0);
  endtask

  task automatic start(input logic [31:0] per, input logic [31:0] div, input logic ok);
    logic [31:0] ld;
    ld = per - 1;
    cfg_period = per;
    cfg_div = div;
    exp_period = per;
    last_clr = -1;
    for (int i = 0; i < NUM_CH; i++) tick_seen[i] = 0;
    exp_wr.push_back({3'd2, ld[15:0]});
    exp_wr.push_back({3'd3, ld[31:16]});
    exp_wr.push_back({3'd1, 16'h0007});
    if (!ok) exp_wr.push_back({3'd1, 16'h0008});
    @(negedge clk);
    enable = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk); #1;
      if (i == 4) check_eq("rd_stat_bus", {tmr_chipselect, tmr_write_n, tmr_address}, {1'b1, 1'b1, 3'd0});
      if (i == 5) check_eq("run_e5", running, 0);
      if (i == 6) begin
        check_eq("run_e6", running, ok);
        check_eq("err_e6", error, !ok);
        check_eq("start_wr_left", exp_wr.size(), 0);
      end
    end
  endtask

  task automatic wait_ticks(input int target, input int budget);
    int k = 0;
    while (tick_count != target && k < budget) begin step(1); k++; end
    check_eq("wait_tick_count", tick_count, target);
  endtask

  task automatic stop_run();
    exp_wr.push_back({3'd1, 16'h0008});
    @(negedge clk);
    enable = 1'b0;
    step(4);
    check_eq("stop_wr_left", exp_wr.size(), 0);
    check_eq("stop_running", running, 0);
  endtask

  initial begin
    int k, c0, clr0, irq0;
    step(3);
    check_reset("rst");
    reset_n = 1'b1;
    step(2);

    // Start with period 100 and dividers {0,3,2,1}
    start(100, {8'd0, 8'd3, 8'd2, 8'd1}, 1'b1);
    k = 0;
    while (!tmr_irq && k < 200) begin step(1); k++; end
    check_eq("irq_seen", tmr_irq, 1);
    c0 = tick_count;
    step(1);
    check_eq("svc_clr_bus", {tmr_chipselect, tmr_write_n, tmr_address}, {1'b1, 1'b0, 3'd0});
    check_eq("svc_cnt_t1", tick_count, c0);
    step(1);
    check_eq("svc_cnt_t2", tick_count, c0 + 1);
    check_eq("svc_tick0_t2", tick[0], 1);
    check_eq("svc_irq_low", tmr_irq, 0);
    wait_ticks(12, 1500);
    step(2);
    check_eq("div_ch0", tick_seen[0], 12);
    check_eq("div_ch1", tick_seen[1], 6);
    check_eq("div_ch2", tick_seen[2], 4);
    check_eq("div_ch3", tick_seen[3], 0);

    // Stop between ticks
    step(20);
    irq0 = irq_rises;
    clr0 = n_clr;
    exp_wr.push_back({3'd1, 16'h0008});
    @(negedge clk);
    enable = 1'b0;
    step(1);
    check_eq("stop_wr_t1", exp_wr.size(), 0);
    check_eq("stop_run_t1", running, 1);
    step(1);
    check_eq("stop_run_t2", running, 0);
    step(300);
    check_eq("stop_frozen", tick_count, 12);
    check_eq("stop_no_irq", irq_rises, irq0);
    check_eq("stop_no_clr", n_clr, clr0);

    // Minimum period and all-ones divider
    start(4, {8'hFF, 8'd0, 8'd0, 8'd1}, 1'b1);
    wait_ticks(255, 255 * 4 + 100);
    step(2);
    check_eq("ff_ch0", tick_seen[0], 255);
    check_eq("ff_ch1", tick_seen[1], 0);
    check_eq("ff_ch3", tick_seen[3], 1);
    stop_run();

    // Configuration error: period below minimum
    clr0 = n_clr;
    cfg_period = 3;
    @(negedge clk);
    enable = 1'b1;
    step(3);
    check_eq("cfg_err", error, 1);
    check_eq("cfg_err_cs", tmr_chipselect, 0);
    check_eq("cfg_err_run", running, 0);
    check_eq("cfg_err_no_clr", n_clr, clr0);
    enable = 1'b0;
    step(2);
    check_eq("cfg_err_clear", error, 0);

    // Verify failure: timer reports not running
    fail_run = 1'b1;
    start(100, 32'd0, 1'b0);
    step(3);
    check_eq("vfy_err", error, 1);
    check_eq("vfy_run", running, 0);
    enable = 1'b0;
    step(2);
    check_eq("vfy_err_clear", error, 0);
    fail_run = 1'b0;

    // Reset during WR_PH, then full restart
    cfg_period = 50;
    cfg_div = {8'd0, 8'd0, 8'd0, 8'd1};
    exp_wr.push_back({3'd2, 16'h0031});
    exp_wr.push_back({3'd3, 16'h0000});
    @(negedge clk);
    enable = 1'b1;
    step(2);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset("midrst");
    check_eq("midrst_wr_left", exp_wr.size(), 0);
    enable = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(2);
    start(50, {8'd0, 8'd0, 8'd0, 8'd1}, 1'b1);
    wait_ticks(3, 400);
    stop_run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
